// File: rtl/inst_mem_loader.sv
// Streams bytes from an upstream source into big-endian 32-bit words and writes
// them to instruction memory, holding the core frozen for the whole load.
module inst_mem_loader #(
  parameter int ADDR_STEP = 4,
  parameter int COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [31:0]        base_addr,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               core_hold,
  output logic               done,
  output logic [COUNT_W-1:0] words_written,
  output logic [1:0]         dbgState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         nextState;
  logic [COUNT_W-1:0] wordTarget;
  logic [COUNT_W-1:0] wordsDone;
  logic [COUNT_W-1:0] wordsInc;
  logic [31:0]        curAddr;
  logic [31:0]        shiftBuf;
  logic [31:0]        memAddrQ;
  logic [31:0]        memWdataQ;
  logic [1:0]         byteIdx;
  logic               byteFire;
  logic               lastByte;
  logic               lastWord;

  // Byte handshake: a byte moves on a rising edge where byte_valid and
  // byte_ready are both 1. byte_ready is a pure function of state (never of
  // byte_valid); upstream keeps byte_data stable while byte_valid waits.
  assign byte_ready = (state == RECV);
  assign byteFire   = byte_valid && byte_ready;
  assign lastByte   = byteFire && (byteIdx == 2'd3);
  assign wordsInc   = wordsDone + COUNT_W'(1);
  assign lastWord   = (wordsInc == wordTarget);

  assign mem_we        = (state == WRITE);
  assign done          = (state == DONE);
  assign core_hold     = (state != IDLE);
  assign mem_addr      = memAddrQ;
  assign mem_wdata     = memWdataQ;
  assign words_written = wordsDone;
  assign dbgState      = state;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (lastByte) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        nextState = lastWord ? DONE : RECV;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wordTarget <= '0;
      wordsDone  <= '0;
      curAddr    <= '0;
      shiftBuf   <= '0;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
      byteIdx    <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            wordTarget <= word_count;
            curAddr    <= base_addr;
            wordsDone  <= '0;
            byteIdx    <= '0;
          end
        end
        RECV: begin
          if (byteFire) begin
            shiftBuf <= {shiftBuf[23:0], byte_data};
            byteIdx  <= byteIdx + 2'd1;
          end
          // Memory-side registers only change here, so they stay quiet
          // whenever the write strobe is low.
          if (lastByte) begin
            memAddrQ  <= curAddr;
            memWdataQ <= {shiftBuf[23:0], byte_data};
          end
        end
        WRITE: begin
          curAddr   <= curAddr + 32'(ADDR_STEP);
          wordsDone <= wordsInc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed loads checked every cycle against a
// transaction-level model, plus literal expectations for each scenario.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  word_count = '0;
  logic [31:0] base_addr = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic [7:0]  words_written;
  logic [1:0]  dbgState;

  inst_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .base_addr(base_addr), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done),
    .words_written(words_written), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state: what the loader must be doing, from the load description
  bit          expBusy = 1'b0;
  bit          pendNext = 1'b0;
  bit          doneNext = 1'b0;
  bit          armed = 1'b0;
  bit          prevRstLow = 1'b0;
  int          modelWords = 0;
  int          byteCnt = 0;
  logic [7:0]  modelCount = '0;
  logic [31:0] modelAddr = '0;
  logic [31:0] accum = '0;
  logic [31:0] lastAddr = '0;
  logic [31:0] lastData = '0;
  logic [63:0] exp_q[$];
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          doneSeen = 0;

  always @(negedge clk) begin : compare
    bit pendNow;
    bit doneNow;
    bit expReady;
    bit busyWas;
    logic [63:0] e;
    pendNow  = pendNext;
    doneNow  = doneNext;
    expReady = expBusy && !pendNow && !doneNow;
    if (armed) begin
      check("mem_we", mem_we, pendNow);
      if (pendNow) begin
        if (exp_q.size() == 0) begin
          check("exp_q empty at write", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("mem_addr", mem_addr, e[63:32]);
          check("mem_wdata", mem_wdata, e[31:0]);
        end
      end else if (prevRstLow) begin
        check("mem_addr after reset", mem_addr, 32'd0);
        check("mem_wdata after reset", mem_wdata, 32'd0);
      end else begin
        check("mem_addr hold", mem_addr, lastAddr);
        check("mem_wdata hold", mem_wdata, lastData);
      end
      check("done", done, doneNow);
      check("core_hold", core_hold, expBusy);
      check("byte_ready", byte_ready, expReady);
      check("words_written", words_written, modelWords);
    end
    if (mem_we === 1'b1) begin
      obsAddr.push_back(mem_addr);
      obsData.push_back(mem_wdata);
    end
    if (done === 1'b1) doneSeen++;
    lastAddr   = mem_addr;
    lastData   = mem_wdata;
    prevRstLow = !reset;
    if (!reset) begin
      armed = 1'b1; expBusy = 1'b0; pendNext = 1'b0; doneNext = 1'b0;
      modelWords = 0; byteCnt = 0;
    end else begin
      pendNext = 1'b0;
      doneNext = 1'b0;
      busyWas  = expBusy;
      if (pendNow) begin
        modelWords++;
        modelAddr = modelAddr + 32'd4;
        if (modelWords == int'(modelCount)) doneNext = 1'b1;
      end
      if (doneNow) expBusy = 1'b0;
      if (start && !busyWas) begin
        modelCount = word_count;
        modelAddr  = base_addr;
        modelWords = 0;
        byteCnt    = 0;
        expBusy    = 1'b1;
        if (word_count == 8'd0) doneNext = 1'b1;
      end
      if (byte_valid && expReady) begin
        accum = {accum[23:0], byte_data};
        byteCnt++;
        if (byteCnt == 4) begin
          exp_q.push_back({modelAddr, accum});
          pendNext = 1'b1;
          byteCnt  = 0;
        end
      end
    end
  end

  logic [7:0] txBytes[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] cnt, input logic [31:0] base);
    start = 1'b1; word_count = cnt; base_addr = base;
    tick();
    start = 1'b0;
    word_count = 8'($urandom_range(0, 255));
    base_addr  = $urandom;
  endtask

  task automatic send_bytes(input int first, input int n, input bit gappy);
    int i = 0;
    int cyc = 0;
    bit v;
    bit rdy;
    while (i < n && cyc < 500) begin
      v = gappy ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      byte_valid = v;
      byte_data  = v ? txBytes[first + i] : 8'($urandom_range(0, 255));
      rdy = byte_ready;
      tick();
      if (v && rdy) i++;
      cyc++;
    end
    byte_valid = 1'b0;
    check("bytes delivered", i, n);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (doneSeen == base && n < 200) begin
      tick();
      n++;
    end
    check("done seen", doneSeen - base, 1);
  endtask

  function automatic logic [31:0] obsA(input int i);
    if (i < obsAddr.size()) return obsAddr[i];
    return 'x;
  endfunction

  function automatic logic [31:0] obsD(input int i);
    if (i < obsData.size()) return obsData[i];
    return 'x;
  endfunction

  task automatic set_bytes8(input logic [63:0] v);
    for (int k = 0; k < 8; k++) txBytes[k] = v[63 - 8*k -: 8];
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " byte_ready"}, byte_ready, 1'b0);
    check({tag, " mem_we"}, mem_we, 1'b0);
    check({tag, " core_hold"}, core_hold, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " words_written"}, words_written, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ob;
    int db;
    reset = 1'b0;
    repeat (3) tick();
    check_idle_zero("reset");
    reset = 1'b1;
    tick();

    // Back-to-back two-word load at 0x40
    set_bytes8(64'h20080005_8C090004);
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd2, 32'h40);
    send_bytes(0, 8, 1'b0);
    wait_done(db);
    check("t1 write count", obsAddr.size() - ob, 2);
    check("t1 addr0", obsA(ob), 32'h40);
    check("t1 data0", obsD(ob), 32'h20080005);
    check("t1 addr1", obsA(ob + 1), 32'h44);
    check("t1 data1", obsD(ob + 1), 32'h8C090004);
    check("t1 words_written", words_written, 32'd2);
    check("t1 core_hold after done", core_hold, 1'b0);

    // Same load with byte_valid gaps
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd2, 32'h40);
    send_bytes(0, 8, 1'b1);
    wait_done(db);
    check("t2 write count", obsAddr.size() - ob, 2);
    check("t2 addr0", obsA(ob), 32'h40);
    check("t2 data0", obsD(ob), 32'h20080005);
    check("t2 addr1", obsA(ob + 1), 32'h44);
    check("t2 data1", obsD(ob + 1), 32'h8C090004);

    // Zero-word load
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd0, 32'h1234);
    wait_done(db);
    tick();
    check("t3 write count", obsAddr.size() - ob, 0);
    check("t3 words_written", words_written, 32'd0);
    check("t3 single done", doneSeen - db, 1);

    // Address wrap at the top of the space
    set_bytes8(64'hDEADBEEF_01234567);
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd2, 32'hFFFFFFFC);
    send_bytes(0, 8, 1'b0);
    wait_done(db);
    check("t4 addr0", obsA(ob), 32'hFFFFFFFC);
    check("t4 data0", obsD(ob), 32'hDEADBEEF);
    check("t4 addr1", obsA(ob + 1), 32'h00000000);
    check("t4 data1", obsD(ob + 1), 32'h01234567);

    // Reset mid-load after 2 bytes of word 2
    set_bytes8(64'h11223344_55667788);
    ob = obsAddr.size();
    do_start(8'd3, 32'h100);
    send_bytes(0, 6, 1'b0);
    reset = 1'b0;
    tick();
    check_idle_zero("t5 in reset");
    reset = 1'b1;
    tick();
    check("t5 write count", obsAddr.size() - ob, 1);
    check("t5 addr0", obsA(ob), 32'h100);
    check("t5 data0", obsD(ob), 32'h11223344);
    txBytes[8] = 8'hCA; txBytes[9] = 8'hFE; txBytes[10] = 8'hBA; txBytes[11] = 8'hBE;
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd1, 32'h200);
    send_bytes(8, 4, 1'b0);
    wait_done(db);
    check("t5 reload count", obsAddr.size() - ob, 1);
    check("t5 reload addr", obsA(ob), 32'h200);
    check("t5 reload data", obsD(ob), 32'hCAFEBABE);
    check("t5 reload words", words_written, 32'd1);

    // start during RECV must be ignored
    set_bytes8(64'hA1B2C3D4_E5F60718);
    ob = obsAddr.size(); db = doneSeen;
    do_start(8'd2, 32'h300);
    send_bytes(0, 2, 1'b0);
    start = 1'b1; base_addr = 32'h800; word_count = 8'd5;
    tick();
    start = 1'b0;
    send_bytes(2, 6, 1'b0);
    wait_done(db);
    check("t6 write count", obsAddr.size() - ob, 2);
    check("t6 addr0", obsA(ob), 32'h300);
    check("t6 data0", obsD(ob), 32'hA1B2C3D4);
    check("t6 addr1", obsA(ob + 1), 32'h304);
    check("t6 data1", obsD(ob + 1), 32'hE5F60718);
    check("t6 words_written", words_written, 32'd2);

    repeat (3) tick();
    check("exp_q drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter: ADDR_STEP, default 4, byte-address increment between consecutive instruction words.
REQ-002 Parameter: COUNT_W, default 8, width of the word-count and progress fields.
REQ-003 The module SHALL have exactly one clock; reset SHALL be synchronous and active-low. Port names are clk and reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-low reset.
REQ-006 Port: start  input  1  load request, sampled in IDLE only.
REQ-007 Port: word_count  input  COUNT_W  number of 32-bit words to load, sampled with start.
REQ-008 Port: base_addr  input  32  byte address of the first word, sampled with start.
REQ-009 Port: byte_valid  input  1  upstream byte available.
REQ-010 Port: byte_data  input  8  upstream byte.
REQ-011 Port: byte_ready  output  1  loader can accept a byte.
REQ-012 Port: mem_we  output  1  instruction-memory write strobe.
REQ-013 Port: mem_addr  output  32  instruction-memory byte address.
REQ-014 Port: mem_wdata  output  32  instruction word to write.
REQ-015 Port: core_hold  output  1  keeps the pipeline PC/IF stage frozen during the load.
REQ-016 Port: done  output  1  one-cycle pulse when the load completes.
REQ-017 Port: words_written  output  COUNT_W  words committed in the current or last load.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-019 IDLE: if start=1, latch word_count and base_addr, clear words_written and the byte index; go to DONE when word_count=0, otherwise go to RECV. start in any other state SHALL be ignored.
REQ-020 A byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1. byte_ready SHALL be 1 only in RECV and SHALL be combinationally independent of byte_valid.
REQ-021 Byte assembly SHALL be big-endian: the 1st byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8], the 4th to [7:0].
REQ-022 When the 4th byte is accepted, the next state SHALL be WRITE. Bytes 1-3 SHALL leave the state at RECV.
REQ-023 WRITE SHALL last exactly one cycle: mem_we=1, mem_addr=current address, mem_wdata=assembled word. byte_ready=0 in WRITE.
REQ-024 On leaving WRITE, the address SHALL increment by ADDR_STEP modulo 2^32 (0xFFFFFFFC+4 wraps to 0x00000000) and words_written SHALL increment by 1. If the new words_written equals the latched word_count, the next state is DONE; otherwise it is RECV.
REQ-025 Latency: the 4th byte is accepted in cycle N, mem_we=1 in cycle N+1, and byte_ready=1 again in cycle N+2 when more words remain.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE. words_written SHALL hold its value until the next accepted start.
REQ-027 core_hold SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-028 mem_we SHALL be 0 outside WRITE. mem_addr and mem_wdata are don't-care when mem_we=0 but SHALL not toggle when mem_we=0.
REQ-029 byte_valid gaps SHALL stall assembly indefinitely without loss or duplication. There is no timeout.

Reset
REQ-030 When reset=0 at a rising edge, the state SHALL become IDLE and byte_ready, mem_we, core_hold and done SHALL become 0. mem_addr, mem_wdata, words_written and the byte index SHALL become 0.
REQ-031 Reset mid-load SHALL discard any partial word and SHALL produce no mem_we pulse. Words already written are not rolled back.
REQ-032 Reset SHALL take priority over start and byte transfers in the same cycle.

Verification
REQ-033 start, word_count=2, base_addr=0x00000040; bytes 20 08 00 05 8C 09 00 04 streamed back-to-back -> writes 0x20080005@0x40 and 0x8C090004@0x44, done pulse, words_written=2, core_hold falls in the cycle after done.
REQ-034 Same load with byte_valid toggling 1,0,0,1 per cycle -> identical writes, no extra mem_we, and byte_ready never 1 in WRITE.
REQ-035 start with word_count=0 -> DONE on the next cycle, done=1 for one cycle, no mem_we, words_written=0.
REQ-036 base_addr=0xFFFFFFFC, word_count=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-037 Reset asserted after 2 bytes of word 2 of a 3-word load -> 1 write total, all outputs 0; a subsequent start from IDLE loads correctly.
REQ-038 start pulsed during RECV with a different base_addr -> ignored, and the original address sequence continues.
